// File: rtl/sram_mem_controller.sv
// Memory-stage controller: splits each 32-bit load/store into two 16-bit SRAM
// accesses (low half, then high half). It holds the pipeline with ready=0 until both halves finish.
module sram_mem_controller #(
  parameter int BASE_ADDR     = 1024,
  parameter int SRAM_AW       = 18,
  parameter int ACCESS_CYCLES = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic               rd_en,
  input  logic [31:0]        address,
  input  logic [31:0]        write_data,
  output logic [31:0]        read_data,
  output logic               ready,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [15:0]        sram_dq_out,
  input  logic [15:0]        sram_dq_in,
  output logic               sram_dq_oe,
  output logic               sram_we_n,
  output logic               sram_ce_n
);
  localparam int         IDX_W      = SRAM_AW - 1;
  localparam logic [3:0] LAST_COUNT = 4'(ACCESS_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

  state_t           r_state;
  state_t           w_next;
  logic [3:0]       r_count;
  logic             r_write;
  logic [IDX_W-1:0] r_idx;
  logic [31:0]      r_wdata;
  logic [31:0]      r_readData;
  logic [SRAM_AW-1:0] r_sramAddr;
  logic [15:0]      r_dqOut;
  logic             r_dqOe;
  logic             r_weN;
  logic             r_ceN;

  logic             w_request;
  logic             w_last;
  logic [IDX_W-1:0] w_idx;
  logic             w_opWrite;
  logic [IDX_W-1:0] w_opIdx;
  logic [31:0]      w_opData;

  assign w_request = wr_en | rd_en;
  assign w_last    = (r_count == LAST_COUNT);
  // Word index wraps modulo the SRAM size; the address offset wraps modulo 2^32.
  assign w_idx     = IDX_W'((address - 32'(BASE_ADDR)) >> 2);

  // The outgoing SRAM registers must be loaded on the IDLE->LOW edge, before the latches hold the request.
  assign w_opWrite = (r_state == IDLE) ? wr_en      : r_write;
  assign w_opIdx   = (r_state == IDLE) ? w_idx      : r_idx;
  assign w_opData  = (r_state == IDLE) ? write_data : r_wdata;

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_request) w_next = LOW;
      LOW:     if (w_last) w_next = HIGH;
      HIGH:    if (w_last) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  assign ready = ((r_state == IDLE) && !w_request) || (r_state == DONE);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= IDLE;
      r_count <= '0;
      r_write <= 1'b0;
      r_idx   <= '0;
      r_wdata <= '0;
    end else begin
      r_state <= w_next;
      if (w_next != r_state)
        r_count <= '0;
      else if ((r_state == LOW) || (r_state == HIGH))
        r_count <= r_count + 4'd1;
      if ((r_state == IDLE) && w_request) begin
        r_write <= wr_en;
        r_idx   <= w_idx;
        r_wdata <= write_data;
      end
    end
  end

  // SRAM pins are registered from the next state so they are valid from the first LOW/HIGH cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_readData <= '0;
      r_sramAddr <= '0;
      r_dqOut    <= '0;
      r_dqOe     <= 1'b0;
      r_weN      <= 1'b1;
      r_ceN      <= 1'b1;
    end else begin
      if (!r_write && w_last) begin
        if (r_state == LOW)  r_readData[15:0]  <= sram_dq_in;
        if (r_state == HIGH) r_readData[31:16] <= sram_dq_in;
      end
      if ((w_next == LOW) || (w_next == HIGH)) begin
        r_sramAddr <= {w_opIdx, (w_next == HIGH)};
        r_dqOut    <= (w_next == HIGH) ? w_opData[31:16] : w_opData[15:0];
        r_dqOe     <= w_opWrite;
        r_weN      <= !w_opWrite;
        r_ceN      <= 1'b0;
      end else begin
        r_dqOe <= 1'b0;
        r_weN  <= 1'b1;
        r_ceN  <= 1'b1;
      end
    end
  end

  assign read_data   = r_readData;
  assign sram_addr   = r_sramAddr;
  assign sram_dq_out = r_dqOut;
  assign sram_dq_oe  = r_dqOe;
  assign sram_we_n   = r_weN;
  assign sram_ce_n   = r_ceN;

endmodule

// File: doc/sram_mem_controller.md
# sram_mem_controller

Memory-stage controller that sequences 32-bit load/store requests onto a 16-bit external SRAM as two half-word accesses. Drives `ready`, which the pipeline inverts into the `freeze` input of the EX/MEM and earlier pipeline registers. This holds the MEM-stage instruction in place until the access finishes. Sits between the EX/MEM register outputs (`MEM_R_EN`, `MEM_W_EN`, ALU result as address, `valRm` as store data) and the SRAM pins.

## Interface
Parameters:
- `BASE_ADDR`, 1024: byte address mapped to SRAM word 0.
- `SRAM_AW`, 18: SRAM half-word address width.
- `ACCESS_CYCLES`, 2: cycles per half-word access; legal values are 1 to 15.

Ports:
- `clk`  in  1  clock. Only clock; all state updates on its rising edge.
- `rst`  in  1  reset, synchronous, active-low.
- `wr_en`  in  1  store request (from `MEM_W_EN_OUT`).
- `rd_en`  in  1  load request (from `MEM_R_EN_OUT`).
- `address`  in  32  byte address (ALU result).
- `write_data`  in  32  store data (`valRm`).
- `read_data`  out  32  load result, registered.
- `ready`  out  1  combinational; 0 means freeze the pipeline.
- `sram_addr`  out  SRAM_AW  half-word address, registered.
- `sram_dq_out`  out  16  write data to SRAM, registered.
- `sram_dq_in`  in  16  read data from SRAM.
- `sram_dq_oe`  out  1  1 means drive `sram_dq_out` onto the SRAM bus.
- `sram_we_n`  out  1  write strobe, active-low.
- `sram_ce_n`  out  1  chip enable, active-low.

## Operation
- Word index: `idx = (address - BASE_ADDR) >> 2`.
  - Subtraction is modulo 2^32.
  - The index is truncated to SRAM_AW-1 bits, so out-of-range addresses wrap.
  - Low half is at `{idx, 1'b0}`; high half is at `{idx, 1'b1}`.
- FSM states: IDLE, LOW, HIGH, DONE.
- IDLE:
  - If `wr_en | rd_en`, latch the operation, `idx` and `write_data`; clear the counter; go to LOW.
  - `wr_en` takes priority when both are high; the access is then a write and `rd_en` is ignored.
  - With no request, stay in IDLE.
- LOW:
  - Outputs: `sram_addr={idx,0}`, `sram_ce_n=0`.
  - Write: `sram_we_n=0`, `sram_dq_oe=1`, `sram_dq_out=write_data[15:0]`.
  - Read: `sram_we_n=1`, `sram_dq_oe=0`. On the last LOW cycle, capture `sram_dq_in` into `read_data[15:0]`.
  - After ACCESS_CYCLES cycles, go to HIGH and clear the counter.
- HIGH: same as LOW using `{idx,1}` and bits [31:16]. After ACCESS_CYCLES cycles, go to DONE.
- DONE:
  - Outputs: `sram_ce_n=1`, `sram_we_n=1`, `sram_dq_oe=0`.
  - Go to IDLE unconditionally. Requests seen in DONE belong to the finished instruction and are not restarted.
- `ready = (IDLE & ~wr_en & ~rd_en) | DONE`.
- `address`, `write_data`, `wr_en` and `rd_en` are ignored outside IDLE.
- `read_data`:
  - Holds its value until the next read overwrites it.
  - Writes never modify it.
  - A partial read aborted by reset leaves it at 0.

## Timing
- Request first seen in IDLE at cycle 0:
  - `ready=0` in cycles 0 .. 2·ACCESS_CYCLES.
  - `ready=1` in cycle 2·ACCESS_CYCLES+1 (DONE).
  - The pipeline advances at the end of the DONE cycle.
- Stall length is 2·ACCESS_CYCLES+1 cycles; with the default this is 5 stall cycles, and ready is high in cycle 5.
- SRAM outputs are registered. Relative to the state they belong to, they are valid from the first cycle of LOW/HIGH.
- Back-to-back accesses: DONE is followed by IDLE. If a new request is present in that IDLE cycle, it starts with `ready=0` immediately. There is exactly one `ready=1` cycle between two accesses.
- Reset (`rst=0` at a clock edge), including mid-access:
  - State goes to IDLE and the counter to 0.
  - `read_data=0`, `sram_addr=0`, `sram_dq_out=0`.
  - `sram_dq_oe=0`, `sram_we_n=1`, `sram_ce_n=1`.
  - After reset, `ready` follows the IDLE rule.
  - An aborted access is dropped, not resumed.

## Test plan
- Idle: `wr_en=rd_en=0` for 10 cycles -> `ready=1` throughout, `sram_ce_n=1`, no SRAM activity.
- Store then load, default parameters:
  - Store `address=1032`, `write_data=0xDEADBEEF` -> `ready` low for 5 cycles, high in cycle 5. Model sees half-word 4 written with 0xBEEF and half-word 5 with 0xDEAD; `we_n` is low for 2 cycles each.
  - Load `1032` -> `read_data=0xDEADBEEF` in the DONE cycle.
- Simultaneous `wr_en=rd_en=1`, `address=1024`, data 0x12345678 -> a write is performed and `read_data` is unchanged.
- Back-to-back loads at 1024 and 1028 held on the inputs -> ready pattern 0,0,0,0,0,1,0,0,0,0,0,1; results correct; `sram_addr` sequence 0,1,2,3.
- Reset asserted in the second HIGH cycle of a load -> next cycle: IDLE, `read_data=0`, `sram_ce_n=1`, `sram_dq_oe=0`. A request then present restarts from LOW.
- Wrap: `address=BASE_ADDR-4` -> `idx` all-ones; `sram_addr` becomes 2^SRAM_AW-2 then 2^SRAM_AW-1.
